countdown_ctrl: RTL and testbench
=================================

Name: countdown_ctrl

Overview:
- Control stage directly upstream of the chained BCD down-counter digits in the countdown timer.
- Debounces the start/pause and clear pushbuttons and runs the run/pause/done state machine.
- Generates the one-cycle `decrease` tick that feeds the least-significant digit, plus a reload pulse that returns all digits to their initial values.
- Consumes the all-digits-zero flag from the counter chain, so the count stops at zero instead of wrapping.

Parameters:
- TICK_DIV, 100000000: clock cycles per decrease tick (1 Hz at 100 MHz); must be ≥ 2.
- DEB_LEN, 4: debounce shift-register length in cycles; must be ≥ 2.

Ports:
- clk  input  1  global clock
- rst_p  input  1  synchronous reset, active-high
- btn_start  input  1  raw start/pause pushbutton, active-high
- btn_clear  input  1  raw clear pushbutton, active-high
- count_zero  input  1  high when every downstream digit value is 0
- decrease  output  1  one-cycle tick to the least-significant down-counter
- reload  output  1  one-cycle pulse; ORed into the counters' reset to reload their initial values
- running  output  1  high while state is RUN
- done  output  1  high while state is DONE (alarm LED)
- state  output  2  current FSM state: 0=IDLE, 1=RUN, 2=PAUSE, 3=DONE

Behaviour:
- Reset (rst_p high at a clk edge):
  - state=IDLE; tick counter=0; debounce shift registers and delayed copies=0.
  - decrease=0, reload=0, running=0, done=0.
  - Reset takes priority over every other event.
- Debounce, per button:
  - A DEB_LEN-bit shift register samples the raw input each edge.
  - Debounced level = AND of all bits.
  - Press pulse = debounced & ~(debounced delayed one cycle).
  - For a steady press from before edge 1, the pulse is high between edges DEB_LEN and DEB_LEN+1, and the state changes at edge DEB_LEN+1.
  - Presses shorter than DEB_LEN cycles produce no pulse. Holding a button produces exactly one pulse.
- Tick counter:
  - Width $clog2(TICK_DIV); counts 0..TICK_DIV-1 and wraps to 0.
  - Increments only in RUN; holds in PAUSE; cleared to 0 in IDLE, DONE and on entry to IDLE.
- decrease:
  - Combinational, high exactly when state==RUN, tick counter==TICK_DIV-1 and count_zero==0.
  - It is never asserted while count_zero is high; this prevents digit wrap to the limit.
- FSM transitions, evaluated at each edge. Priority: clear > count_zero > start.
  - IDLE:
    - clear → IDLE, reload.
    - start with count_zero=1 → DONE.
    - start with count_zero=0 → RUN.
  - RUN:
    - clear → IDLE, reload.
    - count_zero=1 → DONE.
    - start → PAUSE.
  - PAUSE:
    - clear → IDLE, reload.
    - start → RUN; the tick counter resumes from its held value.
    - count_zero is ignored.
  - DONE:
    - clear → IDLE, reload.
    - start is ignored.
- reload: registered; high for exactly the one cycle after the edge at which a clear was accepted. Simultaneous start and clear: clear wins and start is discarded.
- running and done: decoded from registered state (running = state==RUN, done = state==DONE), so they are glitch-free.
- First decrease after entering RUN from IDLE occurs in the TICK_DIV-th cycle spent in RUN.
- Ticks then repeat every TICK_DIV cycles.

Test Plan (TICK_DIV=4, DEB_LEN=2):
- Reset: rst_p high 2 cycles, then low → state=0; decrease, reload, running, done all 0. Repeat with rst_p asserted mid-RUN → IDLE at the next edge, tick counter 0.
- Start: count_zero=0; btn_start high 3 cycles → state=1 at edge 3, running=1. decrease pulses 1 cycle wide in the 4th RUN cycle, then every 4 cycles.
- Pause and resume:
  - Press start after 2 RUN cycles → state=2, no decrease while paused.
  - Press start again → state=1; first decrease arrives 2 cycles later, because the tick count was held.
- Zero: assert count_zero in the same cycle the tick counter reaches 3 → decrease stays 0; next edge state=3, done=1; further start presses leave state at 3.
- Clear:
  - Press clear in DONE → state=0, done=0, reload high for exactly 1 cycle.
  - Press start with count_zero=1 from IDLE → state=3.
- Glitch and priority:
  - btn_start high 1 cycle → no state change.
  - In RUN, btn_start and btn_clear pressed together → state=0 and reload pulses.

Source files
------------

// File: rtl/countdown_ctrl.sv
// rtl/countdown_ctrl.sv - countdown timer control: button debounce, run/pause/done FSM, decrease tick and reload pulse
//
// Ports:
//   clk        global clock
//   rst_p      synchronous reset, active-high
//   btn_start  raw start/pause pushbutton, active-high
//   btn_clear  raw clear pushbutton, active-high
//   count_zero high when every downstream digit is 0
//   decrease   one-cycle tick to the least-significant down-counter digit
//   reload     one-cycle pulse that reloads the digits' initial values
//   running    high while in RUN
//   done       high while in DONE
//   state      current state: 0=IDLE, 1=RUN, 2=PAUSE, 3=DONE
module countdown_ctrl #(
    parameter int TICK_DIV = 100000000,
    parameter int DEB_LEN  = 4
) (
    input  logic       clk,
    input  logic       rst_p,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       count_zero,
    output logic       decrease,
    output logic       reload,
    output logic       running,
    output logic       done,
    output logic [1:0] state
);

    localparam int TW = $clog2(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             cur;
    logic [TW-1:0]      tick_cnt;
    logic [TW-1:0]      tick_next;
    logic [DEB_LEN-1:0] start_sh;
    logic [DEB_LEN-1:0] clear_sh;
    logic               start_deb_d;
    logic               clear_deb_d;
    logic               start_deb;
    logic               clear_deb;
    logic               start_press;
    logic               clear_press;

    // A button counts as pressed only once it has been high for DEB_LEN
    // consecutive samples; the press pulse fires on the rising edge of that
    // debounced level, so a held button yields a single pulse.
    assign start_deb   = &start_sh;
    assign clear_deb   = &clear_sh;
    assign start_press = start_deb & ~start_deb_d;
    assign clear_press = clear_deb & ~clear_deb_d;

    assign tick_next = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + TW'(1);

    // Gating with count_zero keeps the digit chain from wrapping past zero.
    assign decrease = (cur == S_RUN) && (tick_cnt == TICK_LAST) && !count_zero;

    assign running = (cur == S_RUN);
    assign done    = (cur == S_DONE);
    assign state   = cur;

    always_ff @(posedge clk) begin
        if (rst_p) begin
            cur         <= S_IDLE;
            tick_cnt    <= '0;
            start_sh    <= '0;
            clear_sh    <= '0;
            start_deb_d <= 1'b0;
            clear_deb_d <= 1'b0;
            reload      <= 1'b0;
        end else begin
            start_sh    <= {start_sh[DEB_LEN-2:0], btn_start};
            clear_sh    <= {clear_sh[DEB_LEN-2:0], btn_clear};
            start_deb_d <= start_deb;
            clear_deb_d <= clear_deb;
            reload      <= 1'b0;

            // Clear outranks everything, including a simultaneous start.
            if (clear_press) begin
                cur      <= S_IDLE;
                tick_cnt <= '0;
                reload   <= 1'b1;
            end else begin
                case (cur)
                    S_IDLE: begin
                        tick_cnt <= '0;
                        if (start_press) begin
                            cur <= count_zero ? S_DONE : S_RUN;
                        end
                    end
                    S_RUN: begin
                        if (count_zero) begin
                            cur      <= S_DONE;
                            tick_cnt <= '0;
                        end else begin
                            tick_cnt <= tick_next;
                            if (start_press) begin
                                cur <= S_PAUSE;
                            end
                        end
                    end
                    S_PAUSE: begin
                        // Tick count is held so a resume continues mid-period.
                        if (start_press) begin
                            cur <= S_RUN;
                        end
                    end
                    S_DONE: begin
                        tick_cnt <= '0;
                    end
                    default: begin
                        cur      <= S_IDLE;
                        tick_cnt <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_countdown_ctrl.sv
// tb/tb_countdown_ctrl.sv - self-checking bench for countdown_ctrl against a behavioural model
module tb_countdown_ctrl;

    localparam int TD = 4;
    localparam int DL = 2;

    logic       clk;
    logic       rst_p;
    logic       btn_start;
    logic       btn_clear;
    logic       count_zero;
    logic       decrease;
    logic       reload;
    logic       running;
    logic       done;
    logic [1:0] state;

    countdown_ctrl #(.TICK_DIV(TD), .DEB_LEN(DL)) dut (
        .clk        (clk),
        .rst_p      (rst_p),
        .btn_start  (btn_start),
        .btn_clear  (btn_clear),
        .count_zero (count_zero),
        .decrease   (decrease),
        .reload     (reload),
        .running    (running),
        .done       (done),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int dec_seen = 0;
    bit armed = 0;

    // Behavioural model: debounce tracked as a saturating count of
    // consecutive high samples; states as plain integers.
    int m_st   = 0;
    int m_tick = 0;
    int m_rl   = 0;
    int s_run  = 0;
    int c_run  = 0;
    int s_dd   = 0;
    int c_dd   = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic bs, input logic bc, input logic cz);
        int ps, pc, ns, sd, cd;
        if (r) begin
            m_st = 0; m_tick = 0; m_rl = 0;
            s_run = 0; c_run = 0; s_dd = 0; c_dd = 0;
            return;
        end
        sd = (s_run >= DL) ? 1 : 0;
        cd = (c_run >= DL) ? 1 : 0;
        ps = sd && !s_dd;
        pc = cd && !c_dd;
        ns = m_st;
        m_rl = 0;
        if (pc) begin
            ns = 0;
            m_rl = 1;
        end else if (m_st == 0 && ps) ns = cz ? 3 : 1;
        else if (m_st == 1 && cz) ns = 3;
        else if (m_st == 1 && ps) ns = 2;
        else if (m_st == 2 && ps) ns = 1;
        if (ns == 0 || ns == 3) m_tick = 0;
        else if (m_st == 1) m_tick = (m_tick + 1) % TD;
        m_st = ns;
        s_dd = sd;
        c_dd = cd;
        s_run = bs ? ((s_run < DL) ? s_run + 1 : DL) : 0;
        c_run = bc ? ((c_run < DL) ? c_run + 1 : DL) : 0;
    endtask

    // One clock: apply inputs, check outputs against the model, take the edge.
    task automatic cycle(input logic r, input logic bs, input logic bc, input logic cz);
        logic exp_dec;
        rst_p = r; btn_start = bs; btn_clear = bc; count_zero = cz;
        #1;
        if (armed) begin
            exp_dec = (m_st == 1 && m_tick == TD - 1 && !cz);
            chk("state", {6'd0, state}, 8'(m_st));
            chk("running", {7'd0, running}, 8'(m_st == 1));
            chk("done", {7'd0, done}, 8'(m_st == 3));
            chk("reload", {7'd0, reload}, 8'(m_rl));
            chk("decrease", {7'd0, decrease}, {7'd0, exp_dec});
            dec_seen += int'(decrease);
        end
        @(posedge clk);
        model_edge(r, bs, bc, cz);
        armed = 1;
        #1;
    endtask

    task automatic press_start(input logic cz);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, cz);
        cycle(0, 0, 0, cz);
    endtask

    task automatic press_clear();
        for (int i = 0; i < 3; i++) cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
    endtask

    initial begin
        logic bs_r, bc_r, cz_r;
        rst_p = 1; btn_start = 0; btn_clear = 0; count_zero = 0;
        @(posedge clk); #1;

        // Reset
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk("rst_state", {6'd0, state}, 8'd0);
        chk("rst_outs", {4'd0, decrease, reload, running, done}, 8'd0);

        // Start: state goes to RUN at edge 3
        cycle(0, 1, 0, 0);
        cycle(0, 1, 0, 0);
        chk("start_not_yet", {6'd0, state}, 8'd0);
        cycle(0, 1, 0, 0);
        chk("start_run", {6'd0, state}, 8'd1);
        chk("start_running", {7'd0, running}, 8'd1);
        dec_seen = 0;
        for (int i = 0; i < 8; i++) cycle(0, 0, 0, 0);
        chk("two_ticks_in_8", 8'(dec_seen), 8'd2);

        // Pause / resume
        press_start(0);
        chk("paused", {6'd0, state}, 8'd2);
        dec_seen = 0;
        for (int i = 0; i < 6; i++) cycle(0, 0, 0, 0);
        chk("no_tick_paused", 8'(dec_seen), 8'd0);
        press_start(0);
        chk("resumed", {6'd0, state}, 8'd1);

        // Zero at the tick boundary
        for (int i = 0; i < 2 * TD && m_tick != TD - 1; i++) cycle(0, 0, 0, 0);
        chk("reached_last_tick", 8'(m_tick), 8'(TD - 1));
        cycle(0, 0, 0, 1);
        chk("zero_done", {6'd0, state}, 8'd3);
        chk("zero_done_led", {7'd0, done}, 8'd1);
        press_start(1);
        chk("done_ignores_start", {6'd0, state}, 8'd3);

        // Clear in DONE
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        chk("clear_idle", {6'd0, state}, 8'd0);
        chk("clear_reload", {7'd0, reload}, 8'd1);
        cycle(0, 0, 0, 0);
        chk("reload_one_cycle", {7'd0, reload}, 8'd0);
        press_start(1);
        chk("idle_zero_done", {6'd0, state}, 8'd3);
        press_clear();

        // Glitch: 1-cycle press ignored
        cycle(0, 1, 0, 0);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0);
        chk("glitch_ignored", {6'd0, state}, 8'd0);

        // Simultaneous start and clear in RUN
        press_start(0);
        chk("run_again", {6'd0, state}, 8'd1);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0);
        chk("both_clear_wins", {6'd0, state}, 8'd0);
        chk("both_reload", {7'd0, reload}, 8'd1);
        cycle(0, 0, 0, 0);

        // Reset mid-RUN, then first tick after restart must be in 4th RUN cycle
        press_start(0);
        cycle(0, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk("midrun_reset", {6'd0, state}, 8'd0);
        press_start(0);

        // Randomized phase
        bs_r = 0; bc_r = 0; cz_r = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) bs_r = ~bs_r;
            if ($urandom_range(0, 19) == 0) bc_r = ~bc_r;
            if ($urandom_range(0, 15) == 0) cz_r = ~cz_r;
            cycle(($urandom_range(0, 199) == 0), bs_r, bc_r, cz_r);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
